sram_access_arbiter: RTL and testbench

//  Shares one external async SRAM between the capture writer (RPi pixel samples

---
 rtl/sram_access_arbiter.sv | 176 +++++++++++++++++
 tb/tb_sram_access_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_access_arbiter.sv
// sram_access_arbiter
//   Shares one external async SRAM between the capture writer (pixel samples
//   into the frame buffer) and the display reader (VGA scanout). A single-grant
//   FSM drives the SRAM pins with programmable read/write strobe timing.
//   Reads win arbitration. A starvation guard forces a write grant once a write
//   has waited STARVE_MAX cycles.
//
//   Grant timing: the FSM arbitrates in an IDLE cycle. The ack pulse is
//   registered, so it appears in the following cycle T. The state is still
//   IDLE in T, and the transaction's strobes start in T+1.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   rd_req/rd_addr           display read request (level, held until rd_ack)
//   rd_ack                   read accepted, address latched (1-cycle pulse)
//   rd_valid/rd_data         read data strobe; rd_data held until next rd_valid
//   wr_req/wr_addr/wr_data   capture write request (level, held until wr_ack)
//   wr_ack                   write accepted, address/data latched (1-cycle pulse)
//   sram_addr, sram_dq_out   SRAM address bus and data to pins
//   sram_dq_oe               1 = FPGA drives DQ
//   sram_dq_in               SRAM data from pins
//   sram_ce_n/oe_n/we_n      active-low SRAM strobes
//   stat_rd_cnt, stat_wr_cnt, stat_starve_cnt
//                            16-bit wrapping event counters. They exist only
//                            when SRAM_ARB_STATS_EN is defined.
module sram_access_arbiter #(
  parameter int ADDR_W     = 18,
  parameter int DATA_W     = 8,
  parameter int RD_WAIT    = 2,
  parameter int WR_WAIT    = 2,
  parameter int STARVE_MAX = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ack,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_dq_out,
  output logic              sram_dq_oe,
  input  logic [DATA_W-1:0] sram_dq_in,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n
`ifdef SRAM_ARB_STATS_EN
  ,
  output logic [15:0]       stat_rd_cnt,
  output logic [15:0]       stat_wr_cnt,
  output logic [15:0]       stat_starve_cnt
`endif
);

  localparam int MAXW = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
  localparam int CW   = $clog2(MAXW + 1);
  localparam int SW   = $clog2(STARVE_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_WR_SETUP, S_WR_PULSE, S_WR_HOLD
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   wait_cnt, wait_cnt_nxt;
  logic [SW-1:0]   starve;
  logic            arb_idle, starved, grant_wr, grant_rd;
  logic            ce_n_d, oe_n_d, we_n_d, dq_oe_d, rd_valid_d;

  // Arbitrate only in an IDLE cycle that is not already carrying an ack.
  // A pending ack means the requester's req is still the old, granted one.
  assign arb_idle = (state == S_IDLE) && !rd_ack && !wr_ack;
  assign starved  = (starve >= SW'(STARVE_MAX));
  assign grant_wr = arb_idle && wr_req && (!rd_req || starved);
  assign grant_rd = arb_idle && rd_req && !grant_wr;

  // State register, plus the registered outputs and datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      wait_cnt    <= '0;
      starve      <= '0;
      rd_ack      <= 1'b0;
      wr_ack      <= 1'b0;
      rd_valid    <= 1'b0;
      rd_data     <= '0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
      sram_ce_n   <= 1'b1;
      sram_oe_n   <= 1'b1;
      sram_we_n   <= 1'b1;
    end else begin
      state      <= state_nxt;
      wait_cnt   <= wait_cnt_nxt;
      rd_ack     <= grant_rd;
      wr_ack     <= grant_wr;
      rd_valid   <= rd_valid_d;
      sram_dq_oe <= dq_oe_d;
      sram_ce_n  <= ce_n_d;
      sram_oe_n  <= oe_n_d;
      sram_we_n  <= we_n_d;
      if (rd_valid_d) rd_data <= sram_dq_in;
      if (grant_rd) sram_addr <= rd_addr;
      if (grant_wr) begin
        sram_addr   <= wr_addr;
        sram_dq_out <= wr_data;
      end
      if (!wr_req || wr_ack) starve <= '0;
      else if (!starved)     starve <= starve + SW'(1);
    end
  end

  // Next-state logic. wait_cnt counts down the remaining strobe cycles.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    case (state)
      S_IDLE: begin
        if (rd_ack) begin
          state_nxt    = S_RD;
          wait_cnt_nxt = CW'(RD_WAIT - 1);
        end else if (wr_ack) begin
          state_nxt = S_WR_SETUP;
        end
      end
      S_RD: begin
        if (wait_cnt == '0) state_nxt = S_IDLE;
        else                wait_cnt_nxt = wait_cnt - CW'(1);
      end
      S_WR_SETUP: begin
        state_nxt    = S_WR_PULSE;
        wait_cnt_nxt = CW'(WR_WAIT - 1);
      end
      S_WR_PULSE: begin
        if (wait_cnt == '0) state_nxt = S_WR_HOLD;
        else                wait_cnt_nxt = wait_cnt - CW'(1);
      end
      S_WR_HOLD: state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Output decode from the next state, so the registered pins line up with
  // the state they belong to. Going back to IDLE after WR_HOLD drops dq_oe.
  // The next read needs at least two more cycles before oe_n can go low,
  // which gives the DQ bus its turnaround time.
  always_comb begin
    ce_n_d     = (state_nxt == S_IDLE);
    oe_n_d     = (state_nxt != S_RD);
    we_n_d     = (state_nxt != S_WR_PULSE);
    dq_oe_d    = (state_nxt == S_WR_SETUP) || (state_nxt == S_WR_PULSE) ||
                 (state_nxt == S_WR_HOLD);
    rd_valid_d = (state == S_RD) && (state_nxt == S_IDLE);
  end

`ifdef SRAM_ARB_STATS_EN
  // Starvation grants are counted at grant time. They are writes that won
  // while a read was also requesting.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_rd_cnt     <= '0;
      stat_wr_cnt     <= '0;
      stat_starve_cnt <= '0;
    end else begin
      if (rd_ack)             stat_rd_cnt     <= stat_rd_cnt + 16'd1;
      if (wr_ack)             stat_wr_cnt     <= stat_wr_cnt + 16'd1;
      if (grant_wr && rd_req) stat_starve_cnt <= stat_starve_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sram_access_arbiter.sv
module tb_sram_access_arbiter;
  localparam int ADDR_W = 18, DATA_W = 8, RD_WAIT = 2, WR_WAIT = 2, STARVE_MAX = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              rd_req = 1'b0, wr_req = 1'b0;
  logic [ADDR_W-1:0] rd_addr = '0, wr_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              rd_ack, rd_valid, wr_ack;
  logic [DATA_W-1:0] rd_data, sram_dq_out, sram_dq_in;
  logic [ADDR_W-1:0] sram_addr;
  logic              sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;
`ifdef SRAM_ARB_STATS_EN
  logic [15:0]       stat_rd_cnt, stat_wr_cnt, stat_starve_cnt;
`endif

  int vectors = 0, miscompares = 0;

  always #5 clk = ~clk;

  sram_access_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_WAIT(RD_WAIT),
                        .WR_WAIT(WR_WAIT), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_valid(rd_valid),
    .rd_data(rd_data), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ack(wr_ack), .sram_addr(sram_addr), .sram_dq_out(sram_dq_out),
    .sram_dq_oe(sram_dq_oe), .sram_dq_in(sram_dq_in), .sram_ce_n(sram_ce_n),
    .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n)
`ifdef SRAM_ARB_STATS_EN
    , .stat_rd_cnt(stat_rd_cnt), .stat_wr_cnt(stat_wr_cnt),
    .stat_starve_cnt(stat_starve_cnt)
`endif
  );

  // Behavioural async SRAM on the pins, with a preload port for the bench.
  logic [DATA_W-1:0] sram_mem [0:(1<<ADDR_W)-1];
  logic              pl_en = 1'b0;
  logic [ADDR_W-1:0] pl_addr = '0;
  logic [DATA_W-1:0] pl_data = '0;
  always @(posedge clk) begin
    if (pl_en) sram_mem[pl_addr] <= pl_data;
    else if (!sram_ce_n && !sram_we_n && sram_dq_oe) sram_mem[sram_addr] <= sram_dq_out;
  end
  assign sram_dq_in = (!sram_ce_n && !sram_oe_n) ? sram_mem[sram_addr] : '0;

  // Pin-level rules: no oe_n/we_n overlap, no read while driving DQ,
  // and a turnaround cycle after dq_oe drops.
  int   viol = 0;
  logic prev_dq_oe = 1'b0;
  always @(negedge clk) begin
    prev_dq_oe <= sram_dq_oe;
    if ((!sram_oe_n && !sram_we_n) || (!sram_oe_n && sram_dq_oe) ||
        (!sram_oe_n && prev_dq_oe))
      viol <= viol + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic preload(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    tick();
    pl_en = 1'b0;
  endtask

  task automatic wait_ack(input bit is_wr, input string tag);
    int n = 0;
    do begin tick(); n++; end while (!(is_wr ? wr_ack : rd_ack) && n < 20);
    chk(tag, is_wr ? wr_ack : rd_ack, 1'b1);
  endtask

  // Reference memory for the random phase, addresses 0..15.
  logic [7:0] ref_mem [16];
  logic [7:0] exp_q [$];

  initial begin
    int rd_c, wr_c, nrd_before, nrd_after, n_rd, n_wr, rd_wait, wr_wait, max_wait, nvalid;
    bit wr_done;
    logic [3:0] pins;

    // Preload under reset. The DUT is held idle meanwhile.
    @(negedge clk);
    preload(18'h00123, 8'hA5);
    for (int a = 0; a < 16; a++) begin
      ref_mem[a] = 8'hC0 ^ 8'(a);
      preload(18'(a), 8'hC0 ^ 8'(a));
    end

    // 1: reset held with both requests high.
    rd_req = 1'b1; wr_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("reset_pins", {rd_ack, wr_ack, rd_valid, sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe},
          7'b000_111_0);
    end
    chk("reset_addr_data", {sram_addr, rd_data}, '0);
    rst = 1'b0; rd_req = 1'b0; wr_req = 1'b0;
    tick();
    chk("post_reset_idle", {rd_ack, wr_ack, sram_ce_n}, 3'b001);

    // 2: single read.
    rd_req = 1'b1; rd_addr = 18'h00123;
    wait_ack(1'b0, "rd2_ack");
    rd_req = 1'b0;
    tick(); chk("rd2_t1", {sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe, rd_valid}, 5'b00100);
    chk("rd2_addr", sram_addr, 18'h00123);
    tick(); chk("rd2_t2", {sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe, rd_valid}, 5'b00100);
    tick(); chk("rd2_valid", {rd_valid, sram_oe_n, sram_ce_n}, 3'b111);
    chk("rd2_data", rd_data, 8'hA5);
    tick(); chk("rd2_hold", {rd_valid, rd_data}, {1'b0, 8'hA5});

    // 3: single write. The pin sequence per cycle after the ack is
    // {ce_n, oe_n, we_n, dq_oe}.
    wr_req = 1'b1; wr_addr = 18'h3FFFF; wr_data = 8'h5A;
    wait_ack(1'b1, "wr3_ack");
    wr_req = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      case (k)
        1, 4:    pins = 4'b0111;
        2, 3:    pins = 4'b0101;
        default: pins = 4'b1110;
      endcase
      chk($sformatf("wr3_pins_t%0d", k), {sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}, pins);
      if (k <= 4) chk($sformatf("wr3_bus_t%0d", k), {sram_addr, sram_dq_out}, {18'h3FFFF, 8'h5A});
    end
    chk("wr3_mem", sram_mem[18'h3FFFF], 8'h5A);

    // 5: simultaneous requests without starvation. The read goes first.
    rd_req = 1'b1; rd_addr = 18'h00050; wr_req = 1'b1; wr_addr = 18'h00041; wr_data = 8'h77;
    rd_c = -1; wr_c = -1;
    for (int i = 1; i <= 30 && (rd_c < 0 || wr_c < 0); i++) begin
      tick();
      if (rd_ack) begin rd_c = i; rd_req = 1'b0; end
      if (wr_ack) begin wr_c = i; wr_req = 1'b0; end
    end
    chk("sim5_rd_acked", rd_c > 0, 1'b1);
    chk("sim5_wr_after_rd", wr_c > rd_c, 1'b1);
    for (int i = 0; i < 8; i++) tick();

    // 4: continuous reads starve a write until STARVE_MAX waiting cycles.
    rd_req = 1'b1; rd_addr = 18'h00060; wr_req = 1'b1; wr_addr = 18'h00040; wr_data = 8'h99;
    wr_done = 1'b0; wr_c = 0; nrd_before = 0; nrd_after = 0;
    for (int i = 1; i <= 60 && !(wr_done && nrd_after >= 2); i++) begin
      tick();
      if (rd_ack) begin
        if (wr_done) nrd_after++; else nrd_before++;
        rd_addr = rd_addr + 18'd1;
      end
      if (wr_ack) begin wr_c = i; wr_req = 1'b0; wr_done = 1'b1; end
    end
    rd_req = 1'b0;
    chk("starve4_wr_granted", wr_done, 1'b1);
    chk("starve4_not_early", wr_c >= STARVE_MAX + 1, 1'b1);
    chk("starve4_not_late", wr_c <= STARVE_MAX + RD_WAIT + 4, 1'b1);
    chk("starve4_reads_first", nrd_before >= 3, 1'b1);
    chk("starve4_reads_resume", nrd_after >= 2, 1'b1);
`ifdef SRAM_ARB_STATS_EN
    chk("starve4_stat", stat_starve_cnt, 16'd1);
`endif
    for (int i = 0; i < 8; i++) tick();
    chk("starve4_mem", sram_mem[18'h00040], 8'h99);

    // 6: reset mid WR_PULSE, then reset mid read.
    wr_req = 1'b1; wr_addr = 18'h00020; wr_data = 8'h11;
    wait_ack(1'b1, "rst6_wr_ack");
    wr_req = 1'b0;
    tick(); tick();
    chk("rst6_in_pulse", sram_we_n, 1'b0);
    rst = 1'b1;
    tick();
    chk("rst6_abort_wr", {sram_we_n, sram_dq_oe, sram_ce_n, sram_oe_n, wr_ack, rd_valid}, 6'b101100);
    rst = 1'b0;
    tick();
    rd_req = 1'b1; rd_addr = 18'h00005;
    wait_ack(1'b0, "rst6_rd_ack");
    rd_req = 1'b0;
    tick();
    rst = 1'b1;
    nvalid = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (rd_valid) nvalid++;
    end
    chk("rst6_no_rd_valid", nvalid, 0);
    chk("rst6_abort_rd", {sram_ce_n, sram_oe_n}, 2'b11);
    rst = 1'b0;
    tick();

    // Random traffic against the reference memory. Read data must follow
    // grant order.
    n_rd = 0; n_wr = 0; rd_wait = 0; wr_wait = 0; max_wait = 0;
    for (int c = 0; c < 600; c++) begin
      if (c >= 400 && !rd_req && !wr_req && exp_q.size() == 0) break;
      if (rd_valid) begin
        if (exp_q.size() == 0) chk("rnd_spurious_valid", 1'b1, 1'b0);
        else chk("rnd_rd_data", rd_data, exp_q.pop_front());
      end
      if (rd_ack) begin
        exp_q.push_back(ref_mem[rd_addr[3:0]]);
        rd_req = 1'b0; rd_wait = 0; n_rd++;
      end
      if (wr_ack) begin
        ref_mem[wr_addr[3:0]] = wr_data;
        wr_req = 1'b0; wr_wait = 0; n_wr++;
      end
      if (rd_req) rd_wait++;
      if (wr_req) wr_wait++;
      if (rd_wait > max_wait) max_wait = rd_wait;
      if (wr_wait > max_wait) max_wait = wr_wait;
      if (c < 400 && !rd_req && $urandom_range(0, 2) != 0) begin
        rd_req = 1'b1; rd_addr = 18'($urandom_range(0, 15));
      end
      if (c < 400 && !wr_req && $urandom_range(0, 2) == 0) begin
        wr_req = 1'b1; wr_addr = 18'($urandom_range(0, 15)); wr_data = 8'($urandom);
      end
      tick();
    end
    chk("rnd_max_wait", max_wait <= 40, 1'b1);
    chk("rnd_drained", {rd_req, wr_req, 32'(exp_q.size())} == '0, 1'b1);
    chk("rnd_traffic", (n_rd > 20) && (n_wr > 10), 1'b1);
`ifdef SRAM_ARB_STATS_EN
    chk("rnd_stat_rd", stat_rd_cnt, 16'(n_rd));
    chk("rnd_stat_wr", stat_wr_cnt, 16'(n_wr));
`endif
    chk("protocol_viol", viol, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
